// File: rtl/rf_sequencer_if.sv
// Register bank access bus: two combinational read ports and one write port.
// The sequencer is the master; the bank is the slave.
interface rf_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rf_raddr1;
    logic [ADDR_W-1:0] rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
        input  rf_rdata1, rf_rdata2
    );

    modport slave (
        input  rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
        output rf_rdata1, rf_rdata2
    );
endinterface

// File: rtl/rf_sequencer.sv
// Four-state (IDLE/READ/EXEC/WB) sequencer: fetches operands from the register
// bank, executes a small MIPS integer subset and writes the result back.
module rf_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    rf_sequencer_if.master    rf,
    output logic              done,
    output logic              illegal,
    output logic [DATA_W-1:0] result
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t            state_q;
    logic [5:0]        op_q;
    logic [20:0]       lo_q;
    logic [DATA_W-1:0] a_q, b_q, result_q, wdata_q;
    logic [ADDR_W-1:0] raddr1_q, raddr2_q, waddr_q;
    logic              ready_q, we_q, done_q, illegal_q;

    logic [4:0]        rt, rd, shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic              alu_legal;
    logic [DATA_W-1:0] alu_d;
    logic [ADDR_W-1:0] dest_d;

    // rs is only needed for the read address, so it is not kept in lo_q
    assign rt    = lo_q[20:16];
    assign rd    = lo_q[15:11];
    assign shamt = lo_q[10:6];
    assign funct = lo_q[5:0];
    assign imm   = lo_q[15:0];

    always_comb begin
        alu_legal = 1'b1;
        alu_d     = '0;
        dest_d    = ADDR_W'(rd);
        if (op_q == 6'h00) begin
            case (funct)
                6'h20:   alu_d = a_q + b_q;
                6'h22:   alu_d = a_q - b_q;
                6'h24:   alu_d = a_q & b_q;
                6'h25:   alu_d = a_q | b_q;
                6'h2A:   alu_d = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                6'h00:   alu_d = b_q << shamt;
                default: alu_legal = 1'b0;
            endcase
        end else begin
            dest_d = ADDR_W'(rt);
            case (op_q)
                6'h08:   alu_d = a_q + {{(DATA_W-16){imm[15]}}, imm};
                6'h0C:   alu_d = a_q & {{(DATA_W-16){1'b0}}, imm};
                6'h0D:   alu_d = a_q | {{(DATA_W-16){1'b0}}, imm};
                default: alu_legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            wdata_q   <= '0;
            raddr1_q  <= '0;
            raddr2_q  <= '0;
            waddr_q   <= '0;
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_valid && ready_q) begin
                        op_q     <= instr[31:26];
                        lo_q     <= instr[20:0];
                        raddr1_q <= ADDR_W'(instr[25:21]);
                        raddr2_q <= ADDR_W'(instr[20:16]);
                        ready_q  <= 1'b0;
                        state_q  <= READ;
                    end
                end
                READ: begin
                    a_q     <= rf.rf_rdata1;
                    b_q     <= rf.rf_rdata2;
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (alu_legal) begin
                        result_q <= alu_d;
                    end
                    wdata_q   <= alu_legal ? alu_d : result_q;
                    waddr_q   <= dest_d;
                    we_q      <= alu_legal && (dest_d != '0);
                    done_q    <= 1'b1;
                    illegal_q <= !alu_legal;
                    state_q   <= WB;
                end
                WB: begin
                    wdata_q   <= '0;
                    waddr_q   <= '0;
                    raddr1_q  <= '0;
                    raddr2_q  <= '0;
                    we_q      <= 1'b0;
                    done_q    <= 1'b0;
                    illegal_q <= 1'b0;
                    ready_q   <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // An instruction caught in WB by reset must neither write nor retire
    assign rf.rf_we     = we_q && !reset;
    assign done         = done_q && !reset;
    assign illegal      = illegal_q && !reset;
    assign rf.rf_raddr1 = raddr1_q;
    assign rf.rf_raddr2 = raddr2_q;
    assign rf.rf_waddr  = waddr_q;
    assign rf.rf_wdata  = wdata_q;
    assign instr_ready  = ready_q;
    assign result       = result_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: behavioural register bank, directed vector table,
// multi-cycle corner sequences and a randomized run against a reference model.
`timescale 1ns/1ps
module tb_rf_sequencer;
    localparam int AW = 5;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_w = '0;
    logic        instr_ready, done, illegal;
    logic [31:0] result;

    rf_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    rf_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr_w),
        .rf         (bus.master),
        .done       (done),
        .illegal    (illegal),
        .result     (result)
    );

    always #5 clk = ~clk;

    // Behavioural register bank: combinational reads, write on rising edge
    logic [31:0] regs [32];
    logic        poke_en = 1'b0;
    logic [4:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;

    assign bus.rf_rdata1 = regs[bus.rf_raddr1];
    assign bus.rf_rdata2 = regs[bus.rf_raddr2];

    always @(posedge clk) begin
        if (poke_en) regs[poke_addr] <= poke_data;
        else if (bus.rf_we) regs[bus.rf_waddr] <= bus.rf_wdata;
    end

    // Reference state: architectural registers and last result
    logic [31:0] mreg [32];
    logic [31:0] m_result = '0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
        mreg[a] = d;
    endtask

    function automatic void model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                  output logic legal, output logic [31:0] r, output logic [4:0] dest);
        logic [5:0]  op, fn;
        logic [15:0] im;
        op = ins[31:26];
        fn = ins[5:0];
        im = ins[15:0];
        legal = 1'b1;
        r = '0;
        if (op == 6'h00) begin
            dest = ins[15:11];
            case (fn)
                6'h20: r = a + b;
                6'h22: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h00: r = b << ins[10:6];
                default: legal = 1'b0;
            endcase
        end else begin
            dest = ins[20:16];
            case (op)
                6'h08: r = a + {{16{im[15]}}, im};
                6'h0C: r = a & {16'h0000, im};
                6'h0D: r = a | {16'h0000, im};
                default: legal = 1'b0;
            endcase
        end
    endfunction

    // Issue one instruction from IDLE and collect the WB-cycle outputs
    task automatic issue(input logic [31:0] ins, output logic c_we, output logic [4:0] c_waddr,
                         output logic [31:0] c_wdata, output logic c_ill, output logic [31:0] c_res);
        int lat;
        logic [4:0] rs, rt;
        rs = ins[25:21];
        rt = ins[20:16];
        @(negedge clk);
        check("ready_idle", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr_w = ins;
        @(negedge clk);
        instr_valid = 1'b0;
        lat = 1;
        check("ready_read", 32'(instr_ready), 32'd0);
        check("raddr1_read", 32'(bus.rf_raddr1), 32'(rs));
        check("raddr2_read", 32'(bus.rf_raddr2), 32'(rt));
        check("waddr_read", 32'(bus.rf_waddr) | 32'(bus.rf_we) | 32'(done), 32'd0);
        check("wdata_read", bus.rf_wdata, 32'd0);
        while (!done && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        check("raddr1_wb", 32'(bus.rf_raddr1), 32'(rs));
        c_we = bus.rf_we;
        c_waddr = bus.rf_waddr;
        c_wdata = bus.rf_wdata;
        c_ill = illegal;
        c_res = result;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a, b;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ill;
        logic [31:0] res;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        c_we, c_ill, legal, exp_we;
        logic [4:0]  c_waddr, rs, rt, rd, dest;
        logic [31:0] c_wdata, c_res, r, exp_res, ins;
        int          hs, nd, busy;
        int          hs_c [2];
        logic [31:0] wd [2];

        tbl[0]  = '{32'h2005FFFF, 32'h0,        32'h1234,     1'b1, 5'd5,  32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF};
        tbl[1]  = '{32'h00221822, 32'd5,        32'd7,        1'b1, 5'd3,  32'hFFFFFFFE, 1'b0, 32'hFFFFFFFE};
        tbl[2]  = '{32'h0022182A, 32'd5,        32'd7,        1'b1, 5'd3,  32'h00000001, 1'b0, 32'h00000001};
        tbl[3]  = '{32'h000227C0, 32'h0,        32'd1,        1'b1, 5'd4,  32'h80000000, 1'b0, 32'h80000000};
        tbl[4]  = '{32'hFC220000, 32'd1,        32'd2,        1'b0, 5'd0,  32'h80000000, 1'b1, 32'h80000000};
        tbl[5]  = '{32'h00223020, 32'hFFFFFFFF, 32'd1,        1'b1, 5'd6,  32'h00000000, 1'b0, 32'h00000000};
        tbl[6]  = '{32'h00220020, 32'd3,        32'd4,        1'b0, 5'd0,  32'h00000007, 1'b0, 32'h00000007};
        tbl[7]  = '{32'h3027F0F0, 32'hFFFF00FF, 32'h0,        1'b1, 5'd7,  32'h000000F0, 1'b0, 32'h000000F0};
        tbl[8]  = '{32'h34288000, 32'h12340000, 32'h0,        1'b1, 5'd8,  32'h12348000, 1'b0, 32'h12348000};
        tbl[9]  = '{32'h00224824, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd9,  32'hF000F000, 1'b0, 32'hF000F000};
        tbl[10] = '{32'h00225025, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 5'd10, 32'hFFF0FFF0, 1'b0, 32'hFFF0FFF0};
        tbl[11] = '{32'h00225821, 32'd1,        32'd2,        1'b0, 5'd0,  32'hFFF0FFF0, 1'b1, 32'hFFF0FFF0};
        tbl[12] = '{32'h202BFFFE, 32'd10,       32'h0,        1'b1, 5'd11, 32'h00000008, 1'b0, 32'h00000008};
        tbl[13] = '{32'h0022602A, 32'h80000000, 32'd1,        1'b1, 5'd12, 32'h00000001, 1'b0, 32'h00000001};
        tbl[14] = '{32'h00026900, 32'h0,        32'h0F00000F, 1'b1, 5'd13, 32'hF00000F0, 1'b0, 32'hF00000F0};

        for (int i = 0; i < 32; i++) poke(5'(i), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_flags", {29'h0, bus.rf_we, done, illegal}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_raddr", {22'h0, bus.rf_raddr1, bus.rf_raddr2}, 32'd0);
        check("rst_waddr", 32'(bus.rf_waddr), 32'd0);
        check("rst_wdata", bus.rf_wdata, 32'd0);

        foreach (tbl[i]) begin
            ins = tbl[i].ins;
            rs = ins[25:21];
            rt = ins[20:16];
            if (rs != 0) poke(rs, tbl[i].a);
            if (rt != 0) poke(rt, tbl[i].b);
            issue(ins, c_we, c_waddr, c_wdata, c_ill, c_res);
            check($sformatf("v%0d_we", i), 32'(c_we), 32'(tbl[i].we));
            if (!tbl[i].ill) check($sformatf("v%0d_waddr", i), 32'(c_waddr), 32'(tbl[i].waddr));
            check($sformatf("v%0d_wdata", i), c_wdata, tbl[i].wdata);
            check($sformatf("v%0d_illegal", i), 32'(c_ill), 32'(tbl[i].ill));
            check($sformatf("v%0d_result", i), c_res, tbl[i].res);
            m_result = tbl[i].res;
            if (tbl[i].we) mreg[tbl[i].waddr] = tbl[i].wdata;
        end

        // Back-to-back with instr_valid held: second addi must see the first one's write
        instr_valid = 1'b1;
        instr_w = 32'h20010005;
        hs = 0; nd = 0; busy = 0;
        hs_c[0] = 0; hs_c[1] = 0;
        wd[0] = '0; wd[1] = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (hs == 1 && instr_w == 32'h20010005) instr_w = 32'h20220001;
            if (hs == 2) instr_valid = 1'b0;
            if (done && nd < 2) begin wd[nd] = bus.rf_wdata; nd++; end
            if (instr_ready && instr_valid && hs < 2) begin hs_c[hs] = c; hs++; end
            else if (hs == 1 && !instr_ready) busy++;
            if (nd == 2) break;
        end
        instr_valid = 1'b0;
        check("b2b_dones", 32'(nd), 32'd2);
        check("b2b_gap", 32'(hs_c[1] - hs_c[0]), 32'd4);
        check("b2b_busy", 32'(busy), 32'd3);
        check("b2b_wdata0", wd[0], 32'd5);
        check("b2b_wdata1", wd[1], 32'd6);
        mreg[1] = 32'd5; mreg[2] = 32'd6; m_result = 32'd6;

        // Reset during EXEC abandons the add to r13
        poke(5'd13, 32'hAAAA5555);
        @(negedge clk);
        instr_valid = 1'b1; instr_w = 32'h00226820;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1 check("rexec_we_now", 32'(bus.rf_we), 32'd0);
        @(negedge clk);
        check("rexec_flags_rst", {30'h0, bus.rf_we, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rexec_ready", 32'(instr_ready), 32'd1);
        check("rexec_flags", {30'h0, bus.rf_we, done}, 32'd0);
        check("rexec_result", result, 32'd0);
        @(negedge clk);
        check("rexec_done_late", 32'(done), 32'd0);
        check("rexec_bank", regs[13], 32'hAAAA5555);
        m_result = '0;

        // Reset arriving in WB suppresses the write in that same cycle
        poke(5'd14, 32'h00005A5A);
        @(negedge clk);
        instr_valid = 1'b1; instr_w = 32'h202E0003;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rwb_we_before", 32'(bus.rf_we), 32'd1);
        reset = 1'b1;
        #1;
        check("rwb_we_forced", 32'(bus.rf_we), 32'd0);
        check("rwb_done_forced", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rwb_bank", regs[14], 32'h00005A5A);
        check("rwb_ready", 32'(instr_ready), 32'd1);
        m_result = '0;

        // Reset and instr_valid on the same edge: the instruction is dropped
        @(negedge clk);
        reset = 1'b1; instr_valid = 1'b1; instr_w = 32'h00223820;
        @(negedge clk);
        reset = 1'b0; instr_valid = 1'b0;
        check("rv_ready0", 32'(instr_ready), 32'd1);
        @(negedge clk);
        check("rv_ready1", 32'(instr_ready), 32'd1);
        check("rv_raddr", {22'h0, bus.rf_raddr1, bus.rf_raddr2}, 32'd0);

        for (int n = 0; n < 60; n++) begin
            int k;
            logic [5:0] op, fn;
            k  = $urandom_range(0, 9);
            rs = 5'($urandom_range(0, 31));
            rt = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31));
            case (k)
                0: ins = {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), 6'h20};
                1: ins = {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), 6'h22};
                2: ins = {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), 6'h24};
                3: ins = {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), 6'h25};
                4: ins = {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), 6'h2A};
                5: ins = {6'h00, rs, rt, rd, 5'($urandom_range(0, 31)), 6'h00};
                6: ins = {6'h08, rs, rt, 16'($urandom())};
                7: ins = {6'h0C, rs, rt, 16'($urandom())};
                8: ins = {6'h0D, rs, rt, 16'($urandom())};
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        fn = 6'($urandom_range(1, 63));
                        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) fn = 6'h21;
                        ins = {6'h00, rs, rt, rd, 5'd0, fn};
                    end else begin
                        op = 6'($urandom_range(1, 63));
                        if (op == 6'h08 || op == 6'h0C || op == 6'h0D) op = 6'h3F;
                        ins = {op, rs, rt, 16'($urandom())};
                    end
                end
            endcase
            if (rs != 0 && $urandom_range(0, 1) == 0) poke(rs, $urandom());
            if (rt != 0 && $urandom_range(0, 3) == 0) poke(rt, $urandom());
            model(ins, mreg[rs], mreg[rt], legal, r, dest);
            exp_res = legal ? r : m_result;
            exp_we = legal && dest != 0;
            issue(ins, c_we, c_waddr, c_wdata, c_ill, c_res);
            check($sformatf("rnd%0d_we", n), 32'(c_we), 32'(exp_we));
            if (legal) check($sformatf("rnd%0d_waddr", n), 32'(c_waddr), 32'(dest));
            check($sformatf("rnd%0d_wdata", n), c_wdata, exp_res);
            check($sformatf("rnd%0d_illegal", n), 32'(c_ill), 32'(!legal));
            check($sformatf("rnd%0d_result", n), c_res, exp_res);
            m_result = exp_res;
            if (exp_we) mreg[dest] = r;
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
